// File: rtl/i2c_chan_arbiter_pkg.sv
// Shared types and helpers for the I2C channel arbiter and its round-robin picker.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam int DROP_MAX = 255;

  // Next round-robin position after idx, wrapping n-1 back to 0.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping.
module rr_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N     = 12,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;
  int   pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = int'(ptr_i);
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IDX_W'(pos);
      end
      pos = rr_wrap(pos, N);
    end
  end

endmodule

// File: rtl/i2c_chan_arbiter.sv
// Grants one of N I2C channels to the shared slave engine on START, round-robin,
// and holds it until STOP or SCL inactivity timeout on the granted channel.
//
// state   | meaning
// IDLE    | no grant; waiting for a START while the slave engine is ready
// BUSY    | one channel granted; watching its STOP and SCL activity
// RELEASE | grant just dropped; one dead cycle before IDLE
module i2c_chan_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N       = 12,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 50000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [N-1:0]     scl_bus,
  input  logic [N-1:0]     sda_i_bus,
  input  logic             slave_ready,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout_evt,
  output logic [7:0]       drop_cnt
);

  logic [N-1:0] sync_scl, prev_scl, sync_sda, prev_sda;

  for (genvar g = 0; g < N; g++) begin : g_sync
    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;
    always_ff @(posedge clk) begin
      if (!n_rst) begin
        scl_meta_q <= 1'b1; scl_sync_q <= 1'b1; scl_prev_q <= 1'b1;
        sda_meta_q <= 1'b1; sda_sync_q <= 1'b1; sda_prev_q <= 1'b1;
      end else begin
        scl_meta_q <= scl_bus[g];   scl_sync_q <= scl_meta_q; scl_prev_q <= scl_sync_q;
        sda_meta_q <= sda_i_bus[g]; sda_sync_q <= sda_meta_q; sda_prev_q <= sda_sync_q;
      end
    end
    assign sync_scl[g] = scl_sync_q;
    assign prev_scl[g] = scl_prev_q;
    assign sync_sda[g] = sda_sync_q;
    assign prev_sda[g] = sda_prev_q;
  end

  logic [N-1:0] start_q, stop_q, scl_edge_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      start_q    <= '0;
      stop_q     <= '0;
      scl_edge_q <= '0;
    end else begin
      start_q    <= prev_sda & ~sync_sda & sync_scl & prev_scl;
      stop_q     <= ~prev_sda & sync_sda & sync_scl & prev_scl;
      scl_edge_q <= sync_scl ^ prev_scl;
    end
  end

  arb_state_e       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d, win_gnt;
  logic [IDX_W-1:0] idx_q, idx_d, rr_ptr_q, rr_ptr_d, win_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       drop_q, drop_d;
  logic             tevt_q, tevt_d;
  int               drop_sum;

  rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_rr (
    .req_i (start_q),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    tevt_d   = 1'b0;
    drop_sum = 0;
    unique case (state_q)
      IDLE: begin
        if (slave_ready && (|start_q)) begin
          grant_d  = win_gnt;
          idx_d    = win_idx;
          rr_ptr_d = IDX_W'(rr_wrap(int'(win_idx), N));
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        drop_sum = int'(drop_q) + $countones(start_q & ~grant_q);
        drop_d   = (drop_sum > DROP_MAX) ? 8'(DROP_MAX) : 8'(drop_sum);
        // STOP is checked first so it beats a coincident timeout.
        if (stop_q[idx_q]) begin
          grant_d = '0;
          state_d = RELEASE;
        end else if (scl_edge_q[idx_q] || start_q[idx_q]) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tevt_d  = 1'b1;
          grant_d = '0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
      tevt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      tevt_q   <= tevt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = idx_q;
  assign timeout_evt = tevt_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_i2c_chan_arbiter.sv
// Directed bench for i2c_chan_arbiter: expected grants are queued when a START is
// driven and popped when the grant is due, 4 clk edges after the SDA fall.
module tb_i2c_chan_arbiter;

  localparam int N       = 12;
  localparam int IDX_W   = 4;
  localparam int TIMEOUT = 100;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             n_rst;
  logic [N-1:0]     scl_bus, sda_i_bus;
  logic             slave_ready;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             timeout_evt;
  logic [7:0]       drop_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];
  int tevt_seen;

  i2c_chan_arbiter #(.N(N), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .scl_bus     (scl_bus),
    .sda_i_bus   (sda_i_bus),
    .slave_ready (slave_ready),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout_evt (timeout_evt),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  // Grant must be one-hot or zero and grant_valid must track it.
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      vectors++;
      assert ($onehot0(grant) && (grant_valid === (|grant))) else begin
        miscompares++;
        $error("FAIL onehot_inv: observed grant=%0h valid=%0b expected onehot0 with valid=|grant",
               grant, grant_valid);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_on(input int ch);
    sda_i_bus[ch] = 1'b0;
  endtask

  // Pops the oldest expected grant and compares both encodings.
  task automatic check_grant(input string tag);
    int ch;
    chk({tag, "_sb_pending"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      ch = exp_q.pop_front();
      chk({tag, "_grant"}, 32'(grant), 32'(1 << ch));
      chk({tag, "_idx"}, 32'(grant_idx), 32'(ch));
      chk({tag, "_valid"}, 32'(grant_valid), 32'd1);
    end
  endtask

  // Releases via STOP on ch (SCL high, SDA rising); grant drops on the 4th edge.
  task automatic stop_release(input string tag, input int ch, input logic [N-1:0] held);
    sda_i_bus[ch] = 1'b1;
    tick(3);
    chk({tag, "_hold"}, 32'(grant), 32'(held));
    tick(1);
    chk({tag, "_rel"}, 32'(grant), 32'd0);
    chk({tag, "_rel_tevt"}, 32'(timeout_evt), 32'd0);
    tick(1);
    chk({tag, "_idle"}, 32'(grant_valid), 32'd0);
  endtask

  initial begin
    n_rst       = 1'b0;
    scl_bus     = '1;
    sda_i_bus   = '1;
    slave_ready = 1'b1;
    tick(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    chk("rst_tevt", 32'(timeout_evt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    n_rst = 1'b1;
    tick(2);

    // START while the slave engine is busy: ignored and not counted.
    slave_ready = 1'b0;
    start_on(3);
    tick(6);
    chk("notready_grant", 32'(grant), 32'd0);
    chk("notready_drop", 32'(drop_cnt), 32'd0);
    sda_i_bus[3] = 1'b1;
    tick(4);
    slave_ready = 1'b1;

    // Single START on ch3: grant appears on the 4th edge, not the 3rd.
    start_on(3); exp_q.push_back(3);
    tick(3);
    chk("ch3_early", 32'(grant), 32'd0);
    tick(1);
    check_grant("ch3");
    stop_release("ch3_stop", 3, 12'h008);

    // rr_ptr=4: lone ch1 wraps around, leaving rr_ptr=2.
    start_on(1); exp_q.push_back(1);
    tick(4);
    check_grant("ch1");
    stop_release("ch1_stop", 1, 12'h002);

    // rr_ptr=2: ch0 and ch5 together -> ch5, no drop.
    start_on(0); start_on(5); exp_q.push_back(5);
    tick(4);
    check_grant("sim_a");
    chk("sim_a_drop", 32'(drop_cnt), 32'd0);
    sda_i_bus[0] = 1'b1;
    tick(4);
    stop_release("sim_a_stop", 5, 12'h020);

    // rr_ptr=6: ch0 and ch5 again -> wraps to ch0.
    start_on(0); start_on(5); exp_q.push_back(0);
    tick(4);
    check_grant("sim_b");
    chk("sim_b_drop", 32'(drop_cnt), 32'd0);
    sda_i_bus[5] = 1'b1;
    tick(4);
    stop_release("sim_b_stop", 0, 12'h001);

    // ch7 granted; two simultaneous drops, then 300 more on ch1 saturate at 255.
    start_on(7); exp_q.push_back(7);
    tick(4);
    check_grant("ch7");
    start_on(0); start_on(5);
    tick(4);
    chk("drop_pop2", 32'(drop_cnt), 32'd2);
    sda_i_bus[0] = 1'b1; sda_i_bus[5] = 1'b1;
    tick(2);
    for (int i = 0; i < 300; i++) begin
      sda_i_bus[1] = 1'b0;
      tick(2);
      sda_i_bus[1] = 1'b1;
      scl_bus[7]   = ~scl_bus[7];
      tick(2);
    end
    tick(4);
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    chk("drop_hold_grant", 32'(grant), 32'h080);
    stop_release("ch7_stop", 7, 12'h080);

    // ch2 granted with static SCL: timeout exactly 100 edges after the grant edge.
    start_on(2); exp_q.push_back(2);
    tick(4);
    check_grant("ch2");
    tevt_seen = 0;
    for (int i = 1; i < TIMEOUT; i++) begin
      tick(1);
      if (timeout_evt === 1'b1) tevt_seen++;
    end
    chk("to_early", 32'(tevt_seen), 32'd0);
    tick(1);
    chk("to_pulse", 32'(timeout_evt), 32'd1);
    chk("to_grant", 32'(grant), 32'd0);
    tick(1);
    chk("to_once", 32'(timeout_evt), 32'd0);
    chk("to_valid", 32'(grant_valid), 32'd0);
    sda_i_bus[2] = 1'b1;
    tick(4);

    // ch4 granted; repeated START near cycle 90 keeps it alive until a later STOP.
    start_on(4); exp_q.push_back(4);
    tick(4);
    check_grant("ch4");
    tevt_seen = 0;
    tick(85);
    scl_bus[4] = 1'b0;   tick(2);
    sda_i_bus[4] = 1'b1; tick(2);
    scl_bus[4] = 1'b1;   tick(2);
    sda_i_bus[4] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (timeout_evt === 1'b1) tevt_seen++;
    end
    chk("rs_no_timeout", 32'(tevt_seen), 32'd0);
    chk("rs_grant", 32'(grant), 32'h010);
    chk("rs_no_drop", 32'(drop_cnt), 32'd255);
    stop_release("ch4_stop", 4, 12'h010);

    // Reset pulse mid-BUSY on ch9, then a fresh START on ch6 from rr_ptr=0.
    start_on(9); exp_q.push_back(9);
    tick(4);
    check_grant("ch9");
    n_rst = 1'b0;
    sda_i_bus[9] = 1'b1;
    tick(1);
    chk("mrst_grant", 32'(grant), 32'd0);
    chk("mrst_valid", 32'(grant_valid), 32'd0);
    chk("mrst_drop", 32'(drop_cnt), 32'd0);
    chk("mrst_tevt", 32'(timeout_evt), 32'd0);
    n_rst = 1'b1;
    tevt_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (timeout_evt === 1'b1) tevt_seen++;
    end
    chk("mrst_quiet", 32'(tevt_seen), 32'd0);
    start_on(6); exp_q.push_back(6);
    tick(4);
    check_grant("ch6");
    chk("ch6_drop", 32'(drop_cnt), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_chan_arbiter.md
Name: i2c_chan_arbiter

Overview:
- Shares one I2C slave engine and its slave FIFO between N physical I2C channels.
- Watches every channel for a START condition and grants exactly one channel to the slave engine, using round-robin priority.
- Holds the grant until the granted channel issues a STOP or goes silent past a timeout.
- The one-hot grant drives the existing SCL/SDA muxes and the SDA output demux in place of the ad-hoc SDA-low selection.

Parameters:
- N, 12, number of I2C channels.
- IDX_W, 4, width of grant_idx; must be at least ceil(log2(N)).
- TIMEOUT, 50000, number of clk cycles with no SCL edge on the granted channel before a forced release.
- CNT_W, 16, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset, synchronous, active-low.
- scl_bus  in  N  raw SCL of each channel, asynchronous.
- sda_i_bus  in  N  raw SDA input of each channel, asynchronous.
- slave_ready  in  1  slave engine is idle and may accept a new transaction.
- grant  out  N  one-hot channel select; all zero when nothing is granted.
- grant_valid  out  1  equals |grant.
- grant_idx  out  IDX_W  binary index of the granted channel; holds its last value when grant_valid=0.
- timeout_evt  out  1  one-cycle pulse on a forced release.
- drop_cnt  out  8  saturating count of START conditions lost because another channel held the grant.

Behaviour:
- Reset values, applied at the first clk edge with n_rst=0: grant=0, grant_valid=0, grant_idx=0, timeout_evt=0, drop_cnt=0, rr_ptr=0, FSM=IDLE, all synchronizer flops=1.
- Synchronization: each SCL and SDA passes through a 2-FF synchronizer, then one history flop, giving sync and prev values per channel.
- START[i] = prev_sda[i] & ~sync_sda[i] & sync_scl[i] & prev_scl[i].
- STOP[i] = ~prev_sda[i] & sync_sda[i] & sync_scl[i] & prev_scl[i].
- Detection latency: 3 clk cycles from the raw pin edge to the START/STOP pulse.
- FSM IDLE:
  - If slave_ready and any START: select the first requesting channel at or after rr_ptr, wrapping N-1 to 0.
  - Register grant and grant_idx at that edge, so grant_valid rises 1 cycle after the START pulse.
  - Set rr_ptr to winner+1, wrapping N-1 to 0. Clear the timeout counter. Go to BUSY.
  - If slave_ready=0: STARTs are ignored and not counted.
- FSM BUSY:
  - Timeout counter increments each cycle and clears on any edge of sync_scl[grant_idx].
  - A START on the granted channel (repeated START) also clears the counter; no state change.
  - STOP on the granted channel: go to RELEASE.
  - Counter reaches TIMEOUT-1: pulse timeout_evt and go to RELEASE.
  - STOP and timeout in the same cycle: STOP wins and timeout_evt is not pulsed.
  - Each START on a non-granted channel increments drop_cnt by 1 per channel per cycle, saturating at 255. Multiple simultaneous drops add their popcount, still saturating.
- FSM RELEASE: lasts one cycle. grant is cleared at entry, so grant_valid=0 for at least 1 cycle. Then go to IDLE; no re-grant is possible in that cycle.
- Simultaneous STARTs in IDLE: exactly one channel is granted per round-robin; the others are neither granted nor counted as drops.
- Reset asserted mid-transaction: the grant is dropped at the next edge and no timeout_evt is produced.
- grant is always one-hot or zero. The bench asserts this as an invariant.

Decomposition:
- Package i2c_arb_pkg: FSM state enum (IDLE, BUSY, RELEASE), DROP_MAX=255, and a function for the round-robin wrap.
- Sub-module rr_arbiter #(N): combinational request vector plus rr_ptr in, one-hot winner and binary index out. Reused by the team's other shared-resource blocks.
- Synchronizers are inline generate loops; no separate module.

Test Plan:
- Single START on ch3 with slave_ready=1 -> grant=12'h008 and grant_idx=3 at 4 cycles after the raw SDA fall. A STOP on ch3 -> grant=0 for 1 cycle, then IDLE.
- Simultaneous STARTs on ch0 and ch5 with rr_ptr=2 -> ch5 granted, drop_cnt unchanged. After release, new STARTs on ch0 and ch5 -> ch0 granted (rr_ptr=6 wraps).
- Channel 7 granted, then 300 STARTs on ch1 -> drop_cnt=255 (saturates), and grant stays 12'h080.
- Granted ch2 holds SCL static, TIMEOUT=100 -> timeout_evt pulses exactly once, 100 cycles after the last SCL edge. grant=0 on the next cycle.
- Repeated START on the granted ch4 at cycle 90 of 100 -> no timeout at cycle 100; release only on the later STOP.
- n_rst=0 for 1 cycle mid-BUSY -> grant=0, drop_cnt=0, no timeout_evt. A START 5 cycles after reset is granted normally.
